// File: rtl/aurora_tx_framer_if.sv
// Handshake bundle for the Aurora TX framer.
// Covers the user-side write port and the AXI4-Stream TX port.
interface aurora_tx_framer_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] s_axi_tx_tdata;
    logic        s_axi_tx_tvalid;
    logic        s_axi_tx_tready;
    logic        s_axi_tx_tlast;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output s_axi_tx_tdata,
        output s_axi_tx_tvalid,
        input  s_axi_tx_tready,
        output s_axi_tx_tlast
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  s_axi_tx_tdata,
        input  s_axi_tx_tvalid,
        output s_axi_tx_tready,
        input  s_axi_tx_tlast
    );
endinterface

// File: rtl/aurora_tx_framer.sv
// Aurora TX framer: FIFO-buffered fixed-length frames (header + payload).
// Define AURORA_TX_CHECKSUM_EN to append an XOR trailer word to each frame.
module aurora_tx_framer #(
    parameter int FRAME_LEN  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                user_clk,
    input  logic                RST_N,
    input  logic                channel_up,
    aurora_tx_framer_if.slave   bus,
    output logic                frame_sent,
    output logic                frame_drop,
    output logic [7:0]          seq_num
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_LEN   = CW'(FRAME_LEN);
    localparam logic [7:0]    C_LEN8  = 8'(FRAME_LEN);
    localparam logic [7:0]    C_LAST  = 8'(FRAME_LEN - 1);
`ifdef AURORA_TX_CHECKSUM_EN
    localparam logic [7:0]    C_FLAG  = 8'h01;

    typedef enum logic [1:0] {
        S_IDLE, S_HEADER, S_PAYLOAD, S_TRAILER
    } state_t;
`else
    localparam logic [7:0]    C_FLAG  = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE, S_HEADER, S_PAYLOAD
    } state_t;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_wcnt;
    logic [7:0]    r_seq;
    logic          r_sent;
    logic          r_drop;
`ifdef AURORA_TX_CHECKSUM_EN
    logic [31:0]   r_csum;
`endif

    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_last_pl;
    logic          w_done;
    logic          w_flush;
    logic [31:0]   w_head;
    logic [31:0]   w_tdata;
    logic          w_tvalid;
    logic          w_tlast;

    assign w_head     = r_mem[r_rptr];
    assign w_in_ready = channel_up && (r_count < C_DEPTH);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = (r_state == S_PAYLOAD) && channel_up
                        && bus.s_axi_tx_tready;
    assign w_last_pl  = w_pop && (r_wcnt == C_LAST);

    // Losing the channel mid-frame, or while holding words, discards them.
    assign w_flush = !channel_up
                     && ((r_state != S_IDLE) || (r_count != '0));

`ifdef AURORA_TX_CHECKSUM_EN
    assign w_done = (r_state == S_TRAILER) && channel_up
                    && bus.s_axi_tx_tready;
`else
    assign w_done = w_last_pl;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_tvalid    = 1'b0;
        w_tdata     = '0;
        w_tlast     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (channel_up && (r_count >= C_LEN))
                    w_state_nxt = S_HEADER;
            end
            S_HEADER: begin
                w_tvalid = 1'b1;
                w_tdata  = {8'hA5, r_seq, C_FLAG, C_LEN8};
                if (bus.s_axi_tx_tready)
                    w_state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                w_tvalid = 1'b1;
                w_tdata  = w_head;
`ifdef AURORA_TX_CHECKSUM_EN
                if (w_last_pl)
                    w_state_nxt = S_TRAILER;
`else
                w_tlast  = (r_wcnt == C_LAST);
                if (w_last_pl)
                    w_state_nxt = S_IDLE;
`endif
            end
`ifdef AURORA_TX_CHECKSUM_EN
            S_TRAILER: begin
                w_tvalid = 1'b1;
                w_tdata  = r_csum;
                w_tlast  = 1'b1;
                if (bus.s_axi_tx_tready)
                    w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        if (!channel_up)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge user_clk or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_wcnt  <= '0;
            r_seq   <= '0;
            r_sent  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sent  <= w_done;
            r_drop  <= w_flush;
            if (w_done)
                r_seq <= r_seq + 8'd1;
            if (w_flush || w_last_pl)
                r_wcnt <= '0;
            else if (w_pop)
                r_wcnt <= r_wcnt + 8'd1;
            // No push can coincide with a flush: in_ready needs channel_up.
            if (w_flush) begin
                r_rptr  <= r_wptr;
                r_count <= '0;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + 1'b1;
                if (w_pop)
                    r_rptr <= r_rptr + 1'b1;
                if (w_push && !w_pop)
                    r_count <= r_count + 1'b1;
                else if (w_pop && !w_push)
                    r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef AURORA_TX_CHECKSUM_EN
    always_ff @(posedge user_clk or negedge RST_N) begin
        if (!RST_N)
            r_csum <= '0;
        else if (r_state == S_HEADER)
            r_csum <= '0;
        else if (w_pop)
            r_csum <= r_csum ^ w_head;
    end
`endif

    always_ff @(posedge user_clk) begin
        if (w_push)
            r_mem[r_wptr] <= bus.in_data;
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.s_axi_tx_tvalid = w_tvalid;
    assign bus.s_axi_tx_tdata  = w_tdata;
    assign bus.s_axi_tx_tlast  = w_tlast;
    assign frame_sent          = r_sent;
    assign frame_drop          = r_drop;
    assign seq_num             = r_seq;

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Bench for aurora_tx_framer: queue-based frame model checked every cycle,
// plus directed literal checks on captured beats.
module tb_aurora_tx_framer;

    localparam int LEN = 8;
`ifdef AURORA_TX_CHECKSUM_EN
    localparam bit          CS    = 1'b1;
    localparam logic [7:0]  FLAG  = 8'h01;
    localparam int          BEATS = LEN + 2;
    localparam logic [31:0] HDR0  = 32'hA500_0108;
    localparam logic [31:0] HDR4  = 32'hA504_0108;
`else
    localparam bit          CS    = 1'b0;
    localparam logic [7:0]  FLAG  = 8'h00;
    localparam int          BEATS = LEN + 1;
    localparam logic [31:0] HDR0  = 32'hA500_0008;
    localparam logic [31:0] HDR4  = 32'hA504_0008;
`endif

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        p;
    } beat_t;

    logic       user_clk = 1'b0;
    logic       RST_N = 1'b0;
    logic       channel_up = 1'b0;
    logic       frame_sent;
    logic       frame_drop;
    logic [7:0] seq_num;
    bit         bp = 1'b0;

    aurora_tx_framer_if bus();

    aurora_tx_framer #(.FRAME_LEN(LEN), .FIFO_DEPTH(16)) dut (
        .user_clk   (user_clk),
        .RST_N      (RST_N),
        .channel_up (channel_up),
        .bus        (bus.slave),
        .frame_sent (frame_sent),
        .frame_drop (frame_drop),
        .seq_num    (seq_num)
    );

    always #5 user_clk = ~user_clk;

    int errors = 0;
    int checks = 0;
    int n_sent = 0;
    int n_drop = 0;

    logic [31:0] mq[$];
    beat_t       exp_q[$];
    bit          m_act = 1'b0;
    bit          m_sent = 1'b0;
    bit          m_drop = 1'b0;
    logic [7:0]  m_seq = 8'd0;
    logic [31:0] log_d[$];
    logic        log_l[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge user_clk) begin
        if (bp) begin
            #1;
            bus.s_axi_tx_tready = ~bus.s_axi_tx_tready;
        end
    end

    // Model: words queue; a frame is composed when enough words are held.
    always @(negedge user_clk) begin : model
        logic        ir;
        logic [31:0] x;
        beat_t       b;
        if (!RST_N) begin
            mq.delete();
            exp_q.delete();
            m_act  = 1'b0;
            m_sent = 1'b0;
            m_drop = 1'b0;
            m_seq  = 8'd0;
        end else begin
            ir = channel_up && (mq.size() < 16);
            chk("in_ready", bus.in_ready, ir);
            chk("tvalid", bus.s_axi_tx_tvalid, m_act);
            if (m_act && exp_q.size() > 0) begin
                chk("tdata", bus.s_axi_tx_tdata, exp_q[0].d);
                chk("tlast", bus.s_axi_tx_tlast, exp_q[0].l);
            end
            chk("frame_sent", frame_sent, m_sent);
            chk("frame_drop", frame_drop, m_drop);
            chk("seq_num", seq_num, m_seq);
            if (frame_sent) n_sent++;
            if (frame_drop) n_drop++;
            if (bus.s_axi_tx_tvalid && bus.s_axi_tx_tready) begin
                log_d.push_back(bus.s_axi_tx_tdata);
                log_l.push_back(bus.s_axi_tx_tlast);
            end
            m_sent = 1'b0;
            m_drop = 1'b0;
            if (m_act) begin
                if (!channel_up) begin
                    m_drop = 1'b1;
                    mq.delete();
                    exp_q.delete();
                    m_act = 1'b0;
                end else if (bus.s_axi_tx_tready) begin
                    b = exp_q.pop_front();
                    if (b.p) x = mq.pop_front();
                    if (b.l) begin
                        m_sent = 1'b1;
                        m_seq  = m_seq + 8'd1;
                        m_act  = 1'b0;
                    end
                end
            end else if (!channel_up && mq.size() > 0) begin
                m_drop = 1'b1;
                mq.delete();
            end else if (channel_up && mq.size() >= LEN) begin
                x = '0;
                exp_q.push_back('{{8'hA5, m_seq, FLAG, 8'(LEN)},
                                  1'b0, 1'b0});
                for (int i = 0; i < LEN; i++) begin
                    x = x ^ mq[i];
                    exp_q.push_back('{mq[i], (i == LEN-1) && !CS, 1'b1});
                end
                if (CS) exp_q.push_back('{x, 1'b1, 1'b0});
                m_act = 1'b1;
            end
            if (bus.in_valid && ir) mq.push_back(bus.in_data);
        end
    end

    task automatic send(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge user_clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (ok) begin
            @(posedge user_clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("send_timeout", ok, 1);
    endtask

    task automatic wait_sent(input int target);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(posedge user_clk);
            #1;
            ok = (n_sent >= target);
        end
        chk("wait_sent", ok, 1);
    endtask

    task automatic wait_log(input int target);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(posedge user_clk);
            #1;
            ok = (log_d.size() >= target);
        end
        chk("wait_log", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0;
        int d0;
        int acc;
        bus.in_valid        = 1'b1;
        bus.in_data         = 32'hDEAD_0000;
        bus.s_axi_tx_tready = 1'b0;
        repeat (3) @(negedge user_clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_tvalid", bus.s_axi_tx_tvalid, 0);
        chk("rst_tdata", bus.s_axi_tx_tdata, 0);
        chk("rst_seq", seq_num, 0);
        chk("rst_sent", frame_sent, 0);
        chk("rst_drop", frame_drop, 0);
        @(posedge user_clk);
        #1;
        RST_N = 1'b1;
        repeat (2) @(negedge user_clk);
        chk("idle_in_ready", bus.in_ready, 0);
        chk("idle_tvalid", bus.s_axi_tx_tvalid, 0);
        @(posedge user_clk);
        #1;
        bus.in_valid        = 1'b0;
        channel_up          = 1'b1;
        bus.s_axi_tx_tready = 1'b1;

        // Basic frame of words 1..8
        n0 = log_d.size();
        for (int i = 1; i <= 8; i++) send(32'(i));
        wait_sent(1);
        chk("basic_beats", 32'(log_d.size() - n0), BEATS);
        chk("basic_hdr", log_d[n0], HDR0);
        for (int i = 1; i <= 8; i++) chk("basic_pl", log_d[n0+i], 32'(i));
        chk("basic_last7", log_l[n0+7], 0);
        chk("basic_last8", log_l[n0+8], CS ? 0 : 1);
        if (CS) begin
            chk("csum_trailer", log_d[n0+9], 32'h0000_0008);
            chk("csum_tlast", log_l[n0+9], 1);
        end
        chk("basic_seq", seq_num, 1);

        // Backpressure: tready toggles every cycle
        n0 = log_d.size();
        bp = 1'b1;
        for (int i = 0; i < 8; i++) send(32'h100 + 32'(i));
        wait_sent(2);
        bp = 1'b0;
        @(posedge user_clk);
        #2;
        bus.s_axi_tx_tready = 1'b1;
        chk("bp_beats", 32'(log_d.size() - n0), BEATS);
        for (int i = 0; i < 8; i++)
            chk("bp_pl", log_d[n0+1+i], 32'h100 + 32'(i));

        // FIFO full with stalled stream
        bus.s_axi_tx_tready = 1'b0;
        acc = 0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.in_data = 32'h200 + 32'(acc);
            @(negedge user_clk);
            if (bus.in_ready) acc++;
            @(posedge user_clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("full_accepted", 32'(acc), 16);
        @(negedge user_clk);
        chk("full_in_ready", bus.in_ready, 0);
        @(posedge user_clk);
        #1;
        bus.s_axi_tx_tready = 1'b1;
        wait_sent(4);
        chk("full_seq", seq_num, 4);

        // Channel low in IDLE with words held
        for (int i = 0; i < 3; i++) send(32'h500 + 32'(i));
        d0 = n_drop;
        channel_up = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        chk("idle_drop", 32'(n_drop - d0), 1);
        channel_up = 1'b1;

        // Abort after 3 payload beats
        n0 = log_d.size();
        for (int i = 0; i < 8; i++) send(32'h300 + 32'(i));
        wait_log(n0 + 4);
        channel_up = 1'b0;
        d0 = n_drop;
        repeat (3) @(posedge user_clk);
        #1;
        chk("abort_drop", 32'(n_drop - d0), 1);
        chk("abort_tvalid", bus.s_axi_tx_tvalid, 0);
        chk("abort_seq", seq_num, 4);
        channel_up = 1'b1;
        n0 = log_d.size();
        for (int i = 0; i < 8; i++) send(32'h400 + 32'(i));
        wait_sent(5);
        chk("abort_next_hdr", log_d[n0], HDR4);
        chk("abort_next_pl0", log_d[n0+1], 32'h400);
        chk("abort_next_seq", seq_num, 5);

        repeat (3) @(posedge user_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
